// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick for the last count.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count; tick is registered so it is high exactly while the count sits at CNT_MAX
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == CNT_MAX);
    end

    // Counter and tick registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, start + LSB-first data + optional parity + stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_INPUT = 50_000_000,
    parameter int unsigned BAUDRATE    = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = PARITY_NONE,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 sdata,
    output logic                 busy
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_INPUT / BAUDRATE;
    localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be in 5..9");
    end

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 sdata_q, sdata_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 accept_c;
    logic                 baud_tick;

    assign accept_c = ready_q & tx_valid;

    // Bit timing restarts on acceptance so every bit is aligned to the start bit
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (accept_c),
        .tick    (baud_tick)
    );

    // Frame sequencing: next state, shift register, bit/stop counters and line level
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        sdata_d    = sdata_q;
        ready_d    = ready_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    shift_d   = tx_data;
                    parity_d  = (^tx_data) ^ (PARITY == PARITY_ODD);
                    bit_cnt_d = BIT_W'(DATA_BITS - 1);
                    sdata_d   = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    sdata_d = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // bit_cnt_q holds how many data bits remain after the one on the line
                if (baud_tick) begin
                    if (bit_cnt_q != '0) begin
                        sdata_d   = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end else if (PARITY != PARITY_NONE) begin
                        sdata_d = parity_q;
                        state_d = ST_PARITY;
                    end else begin
                        sdata_d    = 1'b1;
                        stop_cnt_d = 1'(STOP_BITS - 1);
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    sdata_d    = 1'b1;
                    stop_cnt_d = 1'(STOP_BITS - 1);
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == 1'b0) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            default: begin
                sdata_d = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            sdata_q    <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            sdata_q    <= sdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = ready_q;
    assign sdata    = sdata_q;
    assign busy     = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter. It takes parallel words through a valid/ready handshake and drives the asynchronous serial line (`sdata`) that `uart_rx` samples. It generates its own bit timing from the system clock, so it needs no external baud strobe. Frame format is a compile-time choice: start bit, LSB-first data, optional parity, 1 or 2 stop bits. The line idles high.

## Interface
- `CLOCK_INPUT`, 50_000_000: system clock frequency in Hz.
- `BAUDRATE`, 9600: line rate in bit/s. `CLKS_PER_BIT = CLOCK_INPUT / BAUDRATE` (integer, truncating); 5208 at the defaults.
- `DATA_BITS`, 8: payload width, legal 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clock` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `tx_data` in DATA_BITS: word to send; sampled only on acceptance.
- `tx_valid` in 1: a word is offered.
- `tx_ready` out 1: high only in IDLE. A word is accepted on any edge where `tx_valid && tx_ready`.
- `sdata` out 1: serial line, registered, idle = 1.
- `busy` out 1: high from the cycle after acceptance until the frame is done; equals `!tx_ready`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE, on accept: latch `tx_data` into the shift register, compute the parity bit from the latched word, load the bit counter, set `sdata <= 0`, go to START.
- Each of START, DATA, PARITY and STOP lasts exactly `CLKS_PER_BIT` clocks per bit.
- DATA shifts out LSB first, DATA_BITS bits.
- Parity bit: even = XOR of the data bits; odd = inverse of that. The PARITY state is skipped when `PARITY = 0`.
- STOP holds `sdata = 1` for `STOP_BITS * CLKS_PER_BIT` clocks, then the block goes to IDLE.
- IDLE lasts at least one cycle between frames. The stop bit is never shortened.
- Changes on `tx_data` or `tx_valid` while busy are ignored. The latched word is what gets sent.
- `tx_valid` held high in IDLE is accepted on the first IDLE edge.
- Reset values: state = IDLE, `sdata = 1`, `tx_ready = 1`, `busy = 0`, counters = 0.
- Reset mid-frame aborts the frame. `sdata` returns to 1 on the reset edge and no partial bits follow.
- `tx_valid` asserted together with `reset` is not accepted.
- Elaboration errors: `CLKS_PER_BIT < 2`, `PARITY > 2`, `STOP_BITS` not 1 or 2, or `DATA_BITS` outside 5..9.

## Timing
- Acceptance edge to start bit on `sdata`: 0 cycles. `sdata` is low starting on the cycle after the accepting edge.
- Frame length N = `(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT` clocks. `tx_ready` is low for exactly N cycles after acceptance.
- Back-to-back frames: the next start bit begins N+1 cycles after the previous start bit.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1 and its wrap is the bit-advance strobe.
- The baud counter restarts at 0 on every acceptance, so bit phase is always aligned to the start bit.
- Bit counter width is `$clog2(DATA_BITS + 1)`.
- Truncation error in `CLKS_PER_BIT` is accepted as is: at the defaults it is 0.006 %, and no fractional correction is applied.

## Structure
- `uart_pkg`: the state enum `tx_state_t` and the parity encoding constants `PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`, shared with `uart_rx` when it gains parity support.
- Sub-module `uart_baud_tick`:
  - Parameterised by `CLKS_PER_BIT`.
  - Inputs: `clock`, `reset`, `restart`.
  - Output: one-cycle `tick`.
- All remaining logic (FSM, shift register, parity, stop-bit count) lives in `uart_tx`.

## Test plan
Simulation parameters: `CLOCK_INPUT = 16`, `BAUDRATE = 1`, giving `CLKS_PER_BIT = 16`.
- 8N1, send 0xA5: `sdata` = 0, then 1,0,1,0,0,1,0,1, then 1, each held 16 cycles. `tx_ready` low for exactly 160 cycles.
- Parity, 0x07: with `PARITY = 1` the parity bit = 1; with `PARITY = 2` it = 0. Frame is 176 cycles.
- `tx_valid` held high with 0x00 then 0xFF: exactly one IDLE cycle (`sdata = 1`, `tx_ready = 1`) between the end of the first stop bit and the second start bit. The second frame decodes as 0xFF.
- `tx_data` changed from 0x3C to 0xC3 one cycle after acceptance: the line carries 0x3C.
- Reset asserted during data bit 4: `sdata = 1` and `tx_ready = 1` from the reset edge. The line stays high until a new acceptance.
- `STOP_BITS = 2`, send 0x81: stop level held 32 cycles, total 176 cycles. A loopback into `uart_rx` recovers 0x81.
